// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC/if_id/id_ex lden and flush, jump redirect, load-use and mul/div stalls.
// Latency: all controls combinational; only the FSM state, wait counter and md_abort are registered.
// Backpressure: mul/div freezes PC/if_id/id_ex until md_done or timeout. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 8
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W     = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_rs1_ren_i,
  input  logic              id_rs2_ren_i,
  input  logic              ex_is_load_i,
  input  logic              ex_regs_wen_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_jump_en_i,
  input  logic [31:0]       ex_jump_addr_i,
  input  logic              ex_md_req_i,
  input  logic              md_done_i,
  output logic              md_start_o,
  output logic              md_abort_o,
  output logic              pc_jump_en_o,
  output logic [31:0]       pc_jump_addr_o,
  output logic              pc_lden_o,
  output logic              if_id_lden_o,
  output logic              if_id_flush_o,
  output logic              id_ex_lden_o,
  output logic              id_ex_flush_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0] perf_md_stall_cnt_o,
  output logic [PERF_W-1:0] perf_lu_stall_cnt_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o,
`endif
  output logic              ex_mem_flush_o
);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_abort_q, md_abort_d;
  logic             md_stall, jump, lu, lu_stall;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_abort_q <= md_abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_abort_d = 1'b0;
    md_stall   = 1'b0;
    md_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        md_start_o = ex_md_req_i;
        if (ex_md_req_i && !md_done_i) begin
          md_stall = 1'b1;
          state_d  = MD_WAIT;
          cnt_d    = '0;
        end
      end
      MD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (md_done_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
          // Give up: release EX so the core can move on, flag it next cycle.
          state_d    = IDLE;
          md_abort_d = 1'b1;
        end else begin
          md_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lu = ex_is_load_i && ex_regs_wen_i && (ex_rd_addr_i != 5'd0) &&
              ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
               (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Priority: mul/div stall, then redirect, then load-use bubble.
  assign jump     = ex_jump_en_i && !md_stall;
  assign lu_stall = lu && !md_stall && !jump;

  assign md_abort_o     = md_abort_q;
  assign pc_jump_en_o   = jump;
  assign pc_jump_addr_o = ex_jump_addr_i;
  assign pc_lden_o      = !md_stall && !lu_stall;
  assign if_id_lden_o   = !md_stall && !lu_stall;
  assign if_id_flush_o  = jump;
  assign id_ex_lden_o   = !md_stall;
  assign id_ex_flush_o  = jump || lu_stall;
  assign ex_mem_flush_o = md_stall;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_md_q, perf_lu_q, perf_fl_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_md_q <= '0;
      perf_lu_q <= '0;
      perf_fl_q <= '0;
    end else begin
      if (md_stall && (perf_md_q != '1)) perf_md_q <= perf_md_q + 1'b1;
      if (lu_stall && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 1'b1;
      if (jump && (perf_fl_q != '1))     perf_fl_q <= perf_fl_q + 1'b1;
    end
  end

  assign perf_md_stall_cnt_o = perf_md_q;
  assign perf_lu_stall_cnt_o = perf_lu_q;
  assign perf_flush_cnt_o    = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios then random traffic against a cycle-level reference model.
// Set PIPE_CTRL_PERF_EN to also check the performance counters.
module tb_pipe_ctrl;
  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic        id_rs1_ren = 0, id_rs2_ren = 0, ex_is_load = 0, ex_regs_wen = 0;
  logic        ex_jump_en = 0, ex_md_req = 0, md_done = 0;
  logic [31:0] ex_jump_addr = '0;
  logic        md_start, md_abort, pc_jump_en, pc_lden, if_id_lden, if_id_flush;
  logic        id_ex_lden, id_ex_flush, ex_mem_flush;
  logic [31:0] pc_jump_addr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_md, perf_lu, perf_fl;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: a mul/div is "in flight" for some number of cycles.
  bit m_busy;
  int m_waited;
  bit m_abort_next;
  int n_md, n_lu, n_fl;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_ren_i(id_rs1_ren), .id_rs2_ren_i(id_rs2_ren),
    .ex_is_load_i(ex_is_load), .ex_regs_wen_i(ex_regs_wen), .ex_rd_addr_i(ex_rd_addr),
    .ex_jump_en_i(ex_jump_en), .ex_jump_addr_i(ex_jump_addr),
    .ex_md_req_i(ex_md_req), .md_done_i(md_done),
    .md_start_o(md_start), .md_abort_o(md_abort),
    .pc_jump_en_o(pc_jump_en), .pc_jump_addr_o(pc_jump_addr),
    .pc_lden_o(pc_lden), .if_id_lden_o(if_id_lden), .if_id_flush_o(if_id_flush),
    .id_ex_lden_o(id_ex_lden), .id_ex_flush_o(id_ex_flush),
`ifdef PIPE_CTRL_PERF_EN
    .perf_md_stall_cnt_o(perf_md), .perf_lu_stall_cnt_o(perf_lu), .perf_flush_cnt_o(perf_fl),
`endif
    .ex_mem_flush_o(ex_mem_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_waited = 0; m_abort_next = 0;
    n_md = 0; n_lu = 0; n_fl = 0;
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit give_up, stall, jmp, hz, lu_app;
    @(negedge clk);
    give_up = m_busy && !md_done && (m_waited == TMO - 1);
    stall   = m_busy ? (!md_done && !give_up) : (ex_md_req && !md_done);
    jmp     = ex_jump_en && !stall;
    hz      = ex_is_load && ex_regs_wen && (ex_rd_addr != 0) &&
              ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
    lu_app  = hz && !stall && !jmp;
    chk("md_start", 32'(md_start), 32'(!m_busy && ex_md_req));
    chk("md_abort", 32'(md_abort), 32'(m_abort_next));
    chk("pc_jump_en", 32'(pc_jump_en), 32'(jmp));
    chk("pc_jump_addr", pc_jump_addr, ex_jump_addr);
    chk("pc_lden", 32'(pc_lden), 32'(!stall && !lu_app));
    chk("if_id_lden", 32'(if_id_lden), 32'(!stall && !lu_app));
    chk("if_id_flush", 32'(if_id_flush), 32'(jmp));
    chk("id_ex_lden", 32'(id_ex_lden), 32'(!stall));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(jmp || lu_app));
    chk("ex_mem_flush", 32'(ex_mem_flush), 32'(stall));
    @(posedge clk);
    if (!rstn) begin
      model_clear();
    end else begin
      n_md += int'(stall); n_lu += int'(lu_app); n_fl += int'(jmp);
      m_abort_next = give_up;
      if (m_busy) begin
        if (md_done || give_up) m_busy = 0;
        else m_waited++;
      end else if (ex_md_req && !md_done) begin
        m_busy = 1; m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic quiet();
    id_rs1_ren = 0; id_rs2_ren = 0; ex_is_load = 0; ex_regs_wen = 0;
    ex_jump_en = 0; ex_md_req = 0; md_done = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs2);
    ex_is_load = 1; ex_regs_wen = 1; ex_rd_addr = rd;
    id_rs2_ren = 1; id_rs2_addr = rs2; id_rs1_ren = 1; id_rs1_addr = 5'd9;
  endtask

  initial begin
    model_clear();
    // Reset with a mul/div request pending: no abort, start pulse once released.
    ex_md_req = 1;
    #2;
    step(); step();
    #1 rstn = 1;
    md_done = 1; step();
    quiet(); step();

    // Mul/div completing five cycles after the request.
    ex_md_req = 1;
    repeat (5) step();
    md_done = 1; step();
    quiet(); step();

    // Load-use on rs2=x5, then the same with rd=x0.
    set_load(5'd5, 5'd5); step();
    quiet(); step();
    set_load(5'd0, 5'd0); step();
    quiet(); step();

    // Jump with simultaneous load-use: jump wins.
    set_load(5'd5, 5'd5); ex_jump_en = 1; ex_jump_addr = 32'h0000_0100; step();
    quiet(); step();

    // Mul/div never completes: timeout, then a one-cycle abort.
    ex_md_req = 1;
    repeat (TMO + 1) step();
    quiet(); step(); step();

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_md", perf_md, 32'(n_md));
    chk("perf_lu", perf_lu, 32'(n_lu));
    chk("perf_fl", perf_fl, 32'(n_fl));
    chk("perf_md_abs", perf_md, 32'd5 + 32'(TMO));
    chk("perf_lu_abs", perf_lu, 32'd1);
    chk("perf_fl_abs", perf_fl, 32'd1);
`endif

    // Reset in the middle of a wait: back to idle with no abort.
    ex_md_req = 1; step(); step();
    rstn = 0; model_clear(); #1;
    step();
    #1 rstn = 1;
    quiet(); step(); step();

    // Random traffic; a mul/div stays in EX while it is outstanding.
    for (int i = 0; i < 400; i++) begin
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_ren  = 1'($urandom); id_rs2_ren = 1'($urandom);
      ex_is_load  = 1'($urandom); ex_regs_wen = 1'($urandom);
      ex_jump_en  = ($urandom_range(0, 3) == 0);
      ex_jump_addr = $urandom;
      ex_md_req   = m_busy ? 1'b1 : ($urandom_range(0, 5) == 0);
      md_done     = ($urandom_range(0, 4) == 0);
      step();
    end

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_md_rand", perf_md, 32'(n_md));
    chk("perf_lu_rand", perf_lu, 32'(n_lu));
    chk("perf_fl_rand", perf_fl, 32'(n_fl));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core with M-extension support.
- Generates load-enable and flush controls for the PC, if_id, id_ex and ex_mem registers.
- Resolves three hazard sources: jump/branch redirect from EX, load-use hazards between ID and EX, and multi-cycle mul/div occupancy of EX.
- Sits beside the pipeline registers. Inputs come from id, ex and the muldiv unit; outputs drive every pipeline register lden/flush pin.

Parameters:
MD_TIMEOUT, 64, maximum MD_WAIT cycles before forced abort (1..255)
CNT_W, 8, width of the mul/div wait counter
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  core clock
rstn  in  1  reset; asynchronous, active-low
id_rs1_addr  in  5  rs1 index of instruction in ID
id_rs2_addr  in  5  rs2 index of instruction in ID
id_rs1_ren  in  1  ID instruction reads rs1
id_rs2_ren  in  1  ID instruction reads rs2
ex_is_load  in  1  instruction in EX is a load
ex_regs_wen  in  1  EX instruction writes rd
ex_rd_addr  in  5  EX destination index
ex_jump_en  in  1  EX resolves a taken jump/branch
ex_jump_addr  in  32  redirect target
ex_md_req  in  1  EX holds a mul/div instruction
md_done  in  1  muldiv result valid this cycle
md_start  out  1  one-cycle start pulse to muldiv
md_abort  out  1  one-cycle pulse on timeout
pc_jump_en  out  1  PC redirect
pc_jump_addr  out  32  redirect target
pc_lden  out  1  PC update enable
if_id_lden  out  1  if_id load enable
if_id_flush  out  1  if_id loads INST_NOP
id_ex_lden  out  1  id_ex load enable
id_ex_flush  out  1  id_ex loads INST_NOP
ex_mem_flush  out  1  ex_mem loads bubble (regs_wen=0)

Behaviour:
- FSM states IDLE, MD_WAIT. Registered: state, wait counter cnt[CNT_W-1:0], md_abort.
- Reset values: state=IDLE, cnt=0, md_abort=0. All other outputs are combinational; with default-zero inputs they evaluate to md_start=0, pc_jump_en=0, pc_jump_addr=ex_jump_addr, all lden=1, all flush=0.
- md_stall = (IDLE & ex_md_req & ~md_done) | (MD_WAIT & ~md_done).
- md_start = IDLE & ex_md_req. Exactly one pulse per mul/div instruction; never asserted in MD_WAIT.
- IDLE -> MD_WAIT when ex_md_req & ~md_done; cnt<=0.
- MD_WAIT -> IDLE on md_done. Stall is released in that same cycle so ex_mem captures the result.
- MD_WAIT: cnt increments each cycle. When cnt==MD_TIMEOUT-1 and ~md_done: go to IDLE, md_abort=1 next cycle for one cycle, and release the stall.
- During md_stall: pc_lden=0, if_id_lden=0, id_ex_lden=0, ex_mem_flush=1. ex_jump_en is ignored.
- Load-use: lu = ex_is_load & ex_regs_wen & (ex_rd_addr!=0) & ((id_rs1_ren & id_rs1_addr==ex_rd_addr) | (id_rs2_ren & id_rs2_addr==ex_rd_addr)).
  - Response: pc_lden=0, if_id_lden=0, id_ex_flush=1 (id_ex_lden=1).
  - Lasts one cycle because the load advances.
- Jump (ex_jump_en & ~md_stall): pc_jump_en=1, pc_jump_addr=ex_jump_addr, if_id_flush=1, id_ex_flush=1, pc_lden=1.
- Priority: md_stall > jump > load-use. On jump with lu both true, the jump wins and the lu stall is suppressed.
- x0 is never a hazard.
- Reset asserted mid-MD_WAIT: state returns to IDLE immediately and no md_abort is issued.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_md_stall_cnt, perf_lu_stall_cnt, perf_flush_cnt (PERF_W each). Each saturating counter increments on a cycle of md_stall, an applied lu stall, or a jump flush respectively. All reset to 0 and wrap is forbidden (saturate at all-ones).
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with ex_md_req=1 held -> state IDLE, md_abort=0. After rstn release, md_start=1 for exactly one cycle.
- ex_md_req=1, md_done rises 5 cycles later -> pc/if_id/id_ex lden=0 and ex_mem_flush=1 for 5 cycles, all released in the md_done cycle, md_start single pulse.
- EX load to x5, ID reads rs2=x5 -> one cycle pc_lden=0, if_id_lden=0, id_ex_flush=1. Repeat with rd=x0 -> no stall.
- ex_jump_en=1, addr=0x0000_0100, simultaneous load-use -> pc_jump_en=1, target 0x100, both flushes=1, pc_lden=1.
- MD_TIMEOUT=4, md_done never -> 4 stall cycles, return to IDLE, md_abort high one cycle.
- PIPE_CTRL_PERF_EN defined, run the above sequence -> perf_md_stall_cnt=9, perf_lu_stall_cnt=1, perf_flush_cnt=1.
